rgb2hsv_pipe: RTL

Parametrised, fully pipelined RGB-to-HSV converter for the pixel datapath. It accepts one pixel per `pclk` and emits HSV one fixed latency later. Video sideband bits (de/hsync/vsync or similar) are delayed to stay aligned with the pixel. Compared with the fixed 8-bit converter it adds channel width, a hue-scaling mode, a valid/sideband pipeline, a reset, a defined tie-break and correct 360→0 hue wrap.

---
 rtl/rgb2hsv_pkg.sv | 19 +
 rtl/div_pipe.sv | 68 ++++++
 rtl/rgb2hsv_pipe.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/rgb2hsv_pkg.sv
// Shared types and constants for the RGB-to-HSV pixel converter.
// Latency: not applicable (declarations only).
// Backpressure: not applicable.
package rgb2hsv_pkg;

  typedef enum logic [1:0] {SEC_R, SEC_G, SEC_B} sector_e;

  localparam int HUE_OFF_R = 0;
  localparam int HUE_OFF_G = 120;
  localparam int HUE_OFF_B = 240;
  localparam int HUE_WRAP  = 360;
  localparam int HUE_SECT  = 60;

  // Pipeline depth in pclk cycles, used by delay-matchers alongside the converter.
  function automatic int rgb2hsv_lat(input int dw);
    return dw + 4;
  endfunction

endpackage

// File: rtl/div_pipe.sv
// Restoring unsigned floor divider, one quotient bit resolved per register stage.
// Latency: QW cycles from num/den to quo.
// Backpressure: none; accepts a new operand pair every cycle.
module div_pipe #(
  parameter int NW     = 14,
  parameter int DW_DEN = 8,
  parameter int QW     = 8
) (
  input  logic              pclk,
  input  logic [NW-1:0]     num,
  input  logic [DW_DEN-1:0] den,
  output logic [QW-1:0]     quo
);

  // Remainder must hold both the numerator and the largest shifted divisor.
  localparam int RW = (NW > DW_DEN + QW) ? NW : DW_DEN + QW;

  logic [RW-1:0]     rem_in [QW];
  logic [RW-1:0]     rem_nx [QW];
  logic [RW-1:0]     rem_q  [QW-1];
  logic [DW_DEN-1:0] den_in [QW];
  logic [DW_DEN-1:0] den_q  [QW-1];
  logic [QW-1:0]     quo_in [QW];
  logic [QW-1:0]     quo_nx [QW];
  logic [QW-1:0]     quo_q  [QW];
  logic [RW-1:0]     dsh;

  // Stage inputs: first stage takes the operands, later stages the previous register.
  always_comb begin
    rem_in[0] = RW'(num);
    den_in[0] = den;
    quo_in[0] = '0;
    for (int i = 1; i < QW; i++) begin
      rem_in[i] = rem_q[i-1];
      den_in[i] = den_q[i-1];
      quo_in[i] = quo_q[i-1];
    end
  end

  // Trial subtract of the divisor aligned to this stage's quotient bit (MSB first).
  always_comb begin
    dsh = '0;
    for (int i = 0; i < QW; i++) begin
      dsh = RW'(den_in[i]) << (QW - 1 - i);
      if (rem_in[i] >= dsh) begin
        rem_nx[i] = rem_in[i] - dsh;
        quo_nx[i] = quo_in[i] | (QW'(1) << (QW - 1 - i));
      end else begin
        rem_nx[i] = rem_in[i];
        quo_nx[i] = quo_in[i];
      end
    end
  end

  // Stage registers; the last stage only needs to keep the finished quotient.
  always_ff @(posedge pclk) begin
    for (int i = 0; i < QW - 1; i++) begin
      rem_q[i] <= rem_nx[i];
      den_q[i] <= den_in[i];
    end
    for (int i = 0; i < QW; i++) begin
      quo_q[i] <= quo_nx[i];
    end
  end

  assign quo = quo_q[QW-1];

endmodule

// File: rtl/rgb2hsv_pipe.sv
// Fully pipelined RGB-to-HSV converter with valid and sideband carried alongside each pixel.
// Latency: DW+4 pclk cycles from the edge sampling rgb_in to the edge presenting the result.
// Backpressure: none; one pixel accepted per cycle, never stalls.
module rgb2hsv_pipe
  import rgb2hsv_pkg::*;
#(
  parameter int DW       = 8,
  parameter int SBW      = 3,
  parameter int HUE_HALF = 1
) (
  input  logic            pclk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [SBW-1:0]  in_sb,
  input  logic [3*DW-1:0] rgb_in,
  output logic            out_valid,
  output logic [SBW-1:0]  out_sb,
  output logic [8:0]      hue_out,
  output logic [DW-1:0]   sat_out,
  output logic [DW-1:0]   val_out
);

  localparam int LAT = rgb2hsv_lat(DW);
  localparam int HNW = DW + 6;
  localparam int SNW = 2 * DW;
  localparam int HSW = (DW > 9) ? DW + 1 : 10;
  localparam logic [DW-1:0] FULL = '1;

  // Valid / sideband pipeline
  logic           vld_q [LAT+1];
  logic [SBW-1:0] sb_q  [LAT+1];

  // Valid and sideband shift with the pixel; clearing them discards everything in flight.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= LAT; i++) begin
        vld_q[i] <= 1'b0;
        sb_q[i]  <= '0;
      end
    end else begin
      vld_q[0] <= in_valid;
      sb_q[0]  <= in_sb;
      for (int i = 1; i <= LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        sb_q[i]  <= sb_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[LAT];
  assign out_sb    = sb_q[LAT];

  // Stage 1: input register
  logic [DW-1:0] r1, g1, b1;

  // Capture the pixel.
  always_ff @(posedge pclk) begin
    {r1, g1, b1} <= rgb_in;
  end

  // Stage 2: max / min / sector
  sector_e       sec_c, sec2;
  logic [DW-1:0] mx_c, mn_c;
  logic [DW-1:0] r2, g2, b2, mx2, mn2;

  // Ties resolve toward R, then G, so every pixel has exactly one sector.
  always_comb begin
    sec_c = SEC_R;
    mx_c  = r1;
    if (r1 >= g1 && r1 >= b1) begin
      sec_c = SEC_R;
      mx_c  = r1;
    end else if (g1 >= b1) begin
      sec_c = SEC_G;
      mx_c  = g1;
    end else begin
      sec_c = SEC_B;
      mx_c  = b1;
    end
    mn_c = r1;
    if (g1 < mn_c) mn_c = g1;
    if (b1 < mn_c) mn_c = b1;
  end

  // Register extrema and sector with the channels still needed for the hue term.
  always_ff @(posedge pclk) begin
    r2   <= r1;
    g2   <= g1;
    b2   <= b1;
    mx2  <= mx_c;
    mn2  <= mn_c;
    sec2 <= sec_c;
  end

  // Stage 3: divider operands, hue offset and direction
  logic [DW-1:0]  d_c, diff_c, den_c, sden_c;
  logic [HNW-1:0] num_c;
  logic [SNW-1:0] snum_c;
  logic [8:0]     off_c;
  logic           sub_c;
  logic [DW-1:0]  den3, sden3, val3;
  logic [HNW-1:0] num3;
  logic [SNW-1:0] snum3;
  logic [8:0]     off3;
  logic           sub3;

  // Hue is off +/- 60*diff/d; gray and black force 0/1 so the dividers never see a zero divisor.
  always_comb begin
    d_c    = mx2 - mn2;
    diff_c = '0;
    off_c  = 9'(HUE_OFF_R);
    sub_c  = 1'b0;
    case (sec2)
      SEC_R: begin
        if (g2 >= b2) begin
          diff_c = g2 - b2;
        end else begin
          diff_c = b2 - g2;
          off_c  = 9'(HUE_WRAP);
          sub_c  = 1'b1;
        end
      end
      SEC_G: begin
        off_c = 9'(HUE_OFF_G);
        if (b2 >= r2) begin
          diff_c = b2 - r2;
        end else begin
          diff_c = r2 - b2;
          sub_c  = 1'b1;
        end
      end
      SEC_B: begin
        off_c = 9'(HUE_OFF_B);
        if (r2 >= g2) begin
          diff_c = r2 - g2;
        end else begin
          diff_c = g2 - r2;
          sub_c  = 1'b1;
        end
      end
      default: ;
    endcase
    if (d_c == '0) begin
      num_c  = '0;
      den_c  = DW'(1);
      snum_c = '0;
      sden_c = DW'(1);
    end else begin
      num_c  = HNW'(diff_c) * HNW'(HUE_SECT);
      den_c  = d_c;
      snum_c = SNW'(d_c) * SNW'(FULL);
      sden_c = mx2;
    end
  end

  // Register divider operands and the terms that bypass the dividers.
  always_ff @(posedge pclk) begin
    num3  <= num_c;
    den3  <= den_c;
    snum3 <= snum_c;
    sden3 <= sden_c;
    off3  <= off_c;
    sub3  <= sub_c;
    val3  <= mx2;
  end

  // Dividers (DW stages each)
  logic [DW-1:0] hq, sq;

  div_pipe #(.NW(HNW), .DW_DEN(DW), .QW(DW)) u_hue_div (
    .pclk (pclk),
    .num  (num3),
    .den  (den3),
    .quo  (hq)
  );

  div_pipe #(.NW(SNW), .DW_DEN(DW), .QW(DW)) u_sat_div (
    .pclk (pclk),
    .num  (snum3),
    .den  (sden3),
    .quo  (sq)
  );

  logic [8:0]    off_d [DW];
  logic          sub_d [DW];
  logic [DW-1:0] val_d [DW];

  // Delay offset, direction and value to line up with the quotients.
  always_ff @(posedge pclk) begin
    off_d[0] <= off3;
    sub_d[0] <= sub3;
    val_d[0] <= val3;
    for (int i = 1; i < DW; i++) begin
      off_d[i] <= off_d[i-1];
      sub_d[i] <= sub_d[i-1];
      val_d[i] <= val_d[i-1];
    end
  end

  // Stage 4: combine offset and quotient
  logic [HSW-1:0] h4;
  logic [DW-1:0]  sat4, val4;

  // Quotient never exceeds 60, so a subtracted hue cannot go negative.
  always_ff @(posedge pclk) begin
    h4   <= sub_d[DW-1] ? HSW'(off_d[DW-1]) - HSW'(hq) : HSW'(off_d[DW-1]) + HSW'(hq);
    sat4 <= sq;
    val4 <= val_d[DW-1];
  end

  // Output stage: wrap 360 to 0, optional halving
  logic [HSW-1:0] h_wr;
  logic [8:0]     hue_c;

  // A red-sector subtraction with zero quotient lands on exactly 360.
  always_comb begin
    h_wr  = (h4 == HSW'(HUE_WRAP)) ? '0 : h4;
    hue_c = (HUE_HALF != 0) ? 9'(h_wr >> 1) : 9'(h_wr);
  end

  // Output registers hold zero while in reset.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      hue_out <= '0;
      sat_out <= '0;
      val_out <= '0;
    end else begin
      hue_out <= hue_c;
      sat_out <= sat4;
      val_out <= val4;
    end
  end

endmodule
